// File: rtl/branch_predictor.sv
// Direct-mapped table of 2-bit saturating counters consulted by ID and trained by EX,
// with resolved-branch and misprediction statistics for debug readout.
module branch_predictor #(
  parameter int          ENTRIES    = 16,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_lookup_pc,
  input  logic        i_lookup_branch,
  output logic        o_prediction,
  input  logic        i_update_valid,
  input  logic [31:0] i_update_pc,
  input  logic        i_update_taken,
  input  logic        i_update_mispredicted,
  output logic [31:0] o_branch_count,
  output logic [31:0] o_mispredict_count
);

  localparam int INDEX_BITS = $clog2(ENTRIES);

  logic [1:0]            counters [ENTRIES];
  logic [INDEX_BITS-1:0] lookup_index;
  logic [INDEX_BITS-1:0] update_index;
  logic [1:0]            update_current;
  logic [1:0]            update_next;
  logic                  unused_pc_bits;

  assign lookup_index = i_lookup_pc[INDEX_BITS+1:2];
  assign update_index = i_update_pc[INDEX_BITS+1:2];

  // Word-offset and tag bits play no part in indexing; tie them off explicitly.
  assign unused_pc_bits = ^{i_lookup_pc[31:INDEX_BITS+2], i_lookup_pc[1:0],
                            i_update_pc[31:INDEX_BITS+2], i_update_pc[1:0]};

  // Combinational read: a same-cycle update to this entry is not bypassed.
  assign o_prediction = reset & i_lookup_branch & counters[lookup_index][1];

  assign update_current = counters[update_index];

  always_comb begin
    update_next = update_current;
    if (i_update_taken) begin
      if (update_current != 2'b11) update_next = update_current + 2'd1;
    end else begin
      if (update_current != 2'b00) update_next = update_current - 2'd1;
    end
  end

  // Reset wins over any update presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) counters[i] <= INIT_STATE;
      o_branch_count     <= 32'd0;
      o_mispredict_count <= 32'd0;
    end else if (i_update_valid) begin
      counters[update_index] <= update_next;
      o_branch_count         <= o_branch_count + 32'd1;
      if (i_update_mispredicted) o_mispredict_count <= o_mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized scoreboard bench for branch_predictor: a strength-per-slot reference model
// queues expected outputs at stimulus time; a negedge monitor pops and compares them.
module tb_branch_predictor;

  localparam int ENTRIES = 16;

  logic        clk;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        lookup_branch;
  logic        prediction;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_mispredicted;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  typedef struct {
    logic        pred;
    logic [31:0] bcount;
    logic [31:0] mcount;
  } expect_t;

  expect_t     exp_q[$];
  int          checks;
  int          failures;
  int          strength [ENTRIES];
  int unsigned model_branches;
  int unsigned model_mispredicts;

  branch_predictor #(.ENTRIES(ENTRIES), .INIT_STATE(2'b01)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .i_lookup_pc           (lookup_pc),
    .i_lookup_branch       (lookup_branch),
    .o_prediction          (prediction),
    .i_update_valid        (update_valid),
    .i_update_pc           (update_pc),
    .i_update_taken        (update_taken),
    .i_update_mispredicted (update_mispredicted),
    .o_branch_count        (branch_count),
    .o_mispredict_count    (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ENTRIES; i++) strength[i] = 1;
    model_branches    = 0;
    model_mispredicts = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus; expected outputs reflect model state before this cycle's edge.
  task automatic applyStimulus(input logic [31:0] lpc, input logic lbr, input logic uv,
                               input logic [31:0] upc, input logic ut, input logic um,
                               input logic rst_n);
    expect_t e;
    @(posedge clk);
    #1;
    reset               = rst_n;
    lookup_pc           = lpc;
    lookup_branch       = lbr;
    update_valid        = uv;
    update_pc           = upc;
    update_taken        = ut;
    update_mispredicted = um;
    e.pred   = rst_n && lbr && (strength[slot(lpc)] >= 2);
    e.bcount = model_branches;
    e.mcount = model_mispredicts;
    exp_q.push_back(e);
    if (!rst_n) begin
      modelReset();
    end else if (uv) begin
      if (ut) strength[slot(upc)] = (strength[slot(upc)] + 1 > 3) ? 3 : strength[slot(upc)] + 1;
      else    strength[slot(upc)] = (strength[slot(upc)] - 1 < 0) ? 0 : strength[slot(upc)] - 1;
      model_branches++;
      if (um) model_mispredicts++;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      expect_t e;
      e = exp_q.pop_front();
      checkOutput("prediction", {31'd0, prediction}, {31'd0, e.pred});
      checkOutput("branch_count", branch_count, e.bcount);
      checkOutput("mispredict_count", mispredict_count, e.mcount);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b0; lookup_pc = '0; lookup_branch = 1'b0;
    update_valid = 1'b0; update_pc = '0; update_taken = 1'b0; update_mispredicted = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);

    // Reset and cold lookups
    applyStimulus(32'h40, 1, 0, 32'h0, 0, 0, 0);
    applyStimulus(32'h40, 1, 0, 32'h0, 0, 0, 1);
    // Same-cycle read-before-write, then trained, neighbour and alias lookups
    applyStimulus(32'h40, 1, 1, 32'h40, 1, 0, 1);
    applyStimulus(32'h40, 1, 0, 32'h0, 0, 0, 1);
    applyStimulus(32'h44, 1, 0, 32'h0, 0, 0, 1);
    applyStimulus(32'h80, 1, 0, 32'h0, 0, 0, 1);
    applyStimulus(32'h43, 0, 0, 32'h0, 0, 0, 1);
    // Saturate up, then walk down through every state to the floor
    for (int i = 0; i < 4; i++) applyStimulus(32'h40, 1, 1, 32'h40, 1, 0, 1);
    for (int i = 0; i < 7; i++) applyStimulus(32'h40, 1, 1, 32'h40, 0, 0, 1);
    applyStimulus(32'h40, 1, 0, 32'h0, 0, 0, 1);
    // Statistics, ignored mispredict flag, then reset during an update
    applyStimulus(32'h48, 1, 1, 32'h48, 1, 1, 1);
    applyStimulus(32'h48, 1, 1, 32'h48, 1, 1, 1);
    applyStimulus(32'h48, 1, 1, 32'h4c, 0, 0, 1);
    applyStimulus(32'h48, 1, 0, 32'h48, 1, 1, 1);
    applyStimulus(32'h48, 1, 1, 32'h48, 1, 1, 0);
    applyStimulus(32'h48, 1, 0, 32'h0, 0, 0, 1);
    applyStimulus(32'h48, 1, 0, 32'h0, 0, 0, 1);

    // Random traffic over a small PC window to force aliasing and saturation
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] lpc, upc;
      lpc = ($urandom() % 2 == 0) ? ($urandom() & 32'h0000_00ff) : $urandom();
      upc = ($urandom() % 2 == 0) ? ($urandom() & 32'h0000_00ff) : $urandom();
      applyStimulus(lpc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), upc,
                    1'($urandom() % 2), 1'($urandom() % 2), ($urandom_range(0, 299) != 0));
    end

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage MIPS pipeline. It holds a direct-mapped table of 2-bit saturating counters that the ID stage consults to produce the taken/not-taken prediction carried down to EX. It is trained by the EX stage's resolved outcome (branch taken, misprediction) for BEQ/BNE. It also keeps resolved-branch and misprediction counters for debug/performance readout.

## Interface
- ENTRIES, 16: number of counter entries; power of two, 2..1024.
- INDEX_BITS, $clog2(ENTRIES): table index width; derived, not overridden.
- INIT_STATE, 2'b01: counter value loaded into every entry on reset (weakly not taken).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- i_lookup_pc  in  32  PC of the instruction currently in ID.
- i_lookup_branch  in  1  ID instruction is BEQ/BNE.
- o_prediction  out  1  1 = predict taken; feeds ID/EX branch_prediction.
- i_update_valid  in  1  EX holds a resolved branch (EX o_branch).
- i_update_pc  in  32  PC of the branch resolving in EX.
- i_update_taken  in  1  actual outcome (EX o_branch_taken).
- i_update_mispredicted  in  1  EX o_mispredicted.
- o_branch_count  out  32  resolved branches since reset.
- o_mispredict_count  out  32  mispredictions since reset.

## Operation
- Index = pc[INDEX_BITS+1:2] for both lookup and update; word offset bits [1:0] ignored; PCs with equal index alias to one entry (no tags).
- Counter encoding: 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T.
- o_prediction = table[lookup_index][1] when i_lookup_branch=1 and reset=1; otherwise 0.
- Update (i_update_valid=1, reset=1): i_update_taken=1 -> entry+1 saturating at 11; i_update_taken=0 -> entry-1 saturating at 00. Only the addressed entry changes.
- Statistics: on each update cycle o_branch_count +1; o_mispredict_count +1 additionally if i_update_mispredicted=1. Both wrap modulo 2^32. i_update_mispredicted ignored when i_update_valid=0.
- i_update_taken/i_update_pc ignored when i_update_valid=0.
- Reset (reset=0 at a rising edge): all entries <- INIT_STATE, both counters <- 0. Any update presented in that cycle is discarded. Reset asserted mid-training discards all learned state.
- No stall input: the ID/EX register captures o_prediction; the predictor holds no per-instruction state.

## Timing
- Lookup is combinational: o_prediction valid in the same cycle as i_lookup_pc/i_lookup_branch (table read, no registered output).
- Update commits at the rising edge ending the cycle with i_update_valid=1; visible to lookups from the next cycle.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value (read-before-write, no bypass).
- Statistics counters are registered; they reflect an update one cycle after it is presented.
- Reset values: all entries INIT_STATE; o_branch_count=0; o_mispredict_count=0; o_prediction=0 while reset=0 and, with default INIT_STATE, after release until trained.
- Throughput: one lookup and one update per cycle, every cycle.

## Test plan
- Reset, then lookup pc=0x00000040, branch=1 -> o_prediction=0; counts 0/0; lookup with branch=0 on a trained entry -> 0.
- Update pc=0x40 taken once -> entry 10; next cycle lookup 0x40 -> 1, lookup 0x44 -> 0.
- Saturation: four taken updates at 0x40 -> 11; one not-taken -> 10, predict 1; second not-taken -> 01, predict 0; four more not-taken -> stays 00.
- Aliasing (ENTRIES=16): update 0x40 taken -> lookup 0x80 (same index 0) predicts 1; 0x44 unaffected.
- Same cycle: lookup 0x40 while updating 0x40 taken from 01 -> o_prediction=0 that cycle, 1 the next.
- Stats/reset: 3 updates, 2 mispredicted, plus 1 cycle with update_valid=0, mispredicted=1 -> counts 3/2; assert reset while update_valid=1 -> counts 0/0, entry at INIT_STATE, update discarded.
